// File: rtl/iq_symbol_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iq_symbol_fifo
// Brief    : First-word-fall-through I/Q pair FIFO between the QAM symbol
//            mapper and the pulse-shaping stage. It has early-full
//            back-pressure and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module iq_symbol_fifo #(
    parameter int DATA_W      = 4,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int FULL_MARGIN = 1
) (
    input  logic              data_clk,
    input  logic              rst,
    input  logic              new_symbol,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] q_data,
    input  logic              out_ready,
    input  logic              clear_err,
    output logic [DATA_W-1:0] i_out,
    output logic [DATA_W-1:0] q_out,
    output logic              out_valid,
    output logic              i_q_data_fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fill_count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] c_depth     = ADDR_W'(0) + (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_full_lvl  = (ADDR_W+1)'(DEPTH - FULL_MARGIN);
    localparam logic [ADDR_W:0] c_zero      = '0;
    localparam logic [ADDR_W:0] c_one       = (ADDR_W+1)'(1);

    logic [2*DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_fill_count;
    logic                r_overflow;

    logic                w_empty;
    logic                w_read;
    logic                w_write;
    logic                w_drop;
    logic [2*DATA_W-1:0] w_head;

    // All status flags come from registered state only, so the mapper's
    // new_symbol never loops back combinationally into fifo_full.
    assign w_empty = (r_fill_count == c_zero);
    assign w_read  = !w_empty && out_ready;
    // A write at capacity is still accepted when the head leaves the same cycle.
    assign w_write = new_symbol && ((r_fill_count != c_depth) || w_read);
    assign w_drop  = new_symbol && !w_write;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge data_clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {i_data, q_data};
        end
    end

    always_ff @(posedge data_clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill_count <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_read})
                2'b10:   r_fill_count <= r_fill_count + c_one;
                2'b01:   r_fill_count <= r_fill_count - c_one;
                default: r_fill_count <= r_fill_count;
            endcase
        end
    end

    // A drop in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge data_clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_err) begin
            r_overflow <= 1'b0;
        end
    end

    assign i_out              = w_empty ? '0 : w_head[2*DATA_W-1:DATA_W];
    assign q_out              = w_empty ? '0 : w_head[DATA_W-1:0];
    assign out_valid          = !w_empty;
    assign fifo_empty         = w_empty;
    assign i_q_data_fifo_full = (r_fill_count >= c_full_lvl);
    assign fill_count         = r_fill_count;
    assign overflow           = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_iq_symbol_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_symbol_fifo
// Brief    : Directed self-checking bench for iq_symbol_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_iq_symbol_fifo;

    logic       data_clk = 1'b0;
    logic       rst = 1'b0;
    logic       new_symbol = 1'b0;
    logic [3:0] i_data = '0;
    logic [3:0] q_data = '0;
    logic       out_ready = 1'b0;
    logic       clear_err = 1'b0;
    logic [3:0] i_out;
    logic [3:0] q_out;
    logic       out_valid;
    logic       i_q_data_fifo_full;
    logic       fifo_empty;
    logic [3:0] fill_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    iq_symbol_fifo #(
        .DATA_W(4), .DEPTH(8), .ADDR_W(3), .FULL_MARGIN(1)
    ) u_dut (
        .data_clk(data_clk), .rst(rst), .new_symbol(new_symbol),
        .i_data(i_data), .q_data(q_data), .out_ready(out_ready),
        .clear_err(clear_err), .i_out(i_out), .q_out(q_out),
        .out_valid(out_valid), .i_q_data_fifo_full(i_q_data_fifo_full),
        .fifo_empty(fifo_empty), .fill_count(fill_count), .overflow(overflow)
    );

    always #5 data_clk = ~data_clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge data_clk);
        #1;
    endtask

    task automatic write1(input logic [3:0] i_v, input logic [3:0] q_v);
        new_symbol = 1'b1; i_data = i_v; q_data = q_v;
        tick();
        new_symbol = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; new_symbol = 1'b1; i_data = 4'h5; q_data = 4'h6;
        tick(); tick();
        rst = 1'b0; new_symbol = 1'b0;
        n_tests++; if (fill_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fill_count); end
        n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_tests++; if ({i_out, q_out} !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", {i_out, q_out}); end
        n_tests++; if (overflow !== 1'b0 || i_q_data_fifo_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got ovf=%b full=%b exp 0 0", overflow, i_q_data_fifo_full);
        end
    endtask

    task automatic test_single_write();
        out_ready = 1'b0;
        write1(4'b1001, 4'b0011);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
        n_tests++; if (i_out !== 4'd9 || q_out !== 4'd3) begin
            n_fail++; $display("FAIL single_data got i=%0d q=%0d exp i=9 q=3", i_out, q_out);
        end
        n_tests++; if (fill_count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", fill_count); end
    endtask

    task automatic test_full_threshold();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            write1(4'(k + 1), ~4'(k + 1));
            if (k == 5) begin
                n_tests++; if (i_q_data_fifo_full !== 1'b0) begin n_fail++; $display("FAIL full_at6 got %b exp 0", i_q_data_fifo_full); end
            end
            if (k == 6) begin
                n_tests++; if (i_q_data_fifo_full !== 1'b1 || fill_count !== 4'd7) begin
                    n_fail++; $display("FAIL full_at7 got full=%b cnt=%0d exp 1 7", i_q_data_fifo_full, fill_count);
                end
            end
        end
        n_tests++; if (fill_count !== 4'd8 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_8th got cnt=%0d ovf=%b exp 8 0", fill_count, overflow);
        end
        write1(4'hF, 4'hF);
        n_tests++; if (overflow !== 1'b1 || fill_count !== 4'd8) begin
            n_fail++; $display("FAIL drop_9th got ovf=%b cnt=%0d exp 1 8", overflow, fill_count);
        end
        n_tests++; if (i_out !== 4'd1 || q_out !== 4'hE) begin
            n_fail++; $display("FAIL drop_head got i=%h q=%h exp 1 e", i_out, q_out);
        end
        // Drop coinciding with clear_err: set wins, then a lone clear clears.
        clear_err = 1'b1;
        write1(4'hF, 4'hF);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clear_vs_drop got %b exp 1", overflow); end
        tick();
        clear_err = 1'b0;
        n_tests++; if (overflow !== 1'b0 || fill_count !== 4'd8) begin
            n_fail++; $display("FAIL clear_err got ovf=%b cnt=%0d exp 0 8", overflow, fill_count);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_i;
        logic [3:0] exp_q;
        out_ready = 1'b1;
        write1(4'hA, 4'h5);
        out_ready = 1'b0;
        n_tests++; if (fill_count !== 4'd8 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL simul_full got cnt=%0d ovf=%b exp 8 0", fill_count, overflow);
        end
        for (int k = 0; k < 8; k++) begin
            exp_i = (k == 7) ? 4'hA : 4'(k + 2);
            exp_q = (k == 7) ? 4'h5 : ~4'(k + 2);
            n_tests++; if (out_valid !== 1'b1 || i_out !== exp_i || q_out !== exp_q) begin
                n_fail++; $display("FAIL drain_%0d got v=%b i=%h q=%h exp 1 %h %h", k, out_valid, i_out, q_out, exp_i, exp_q);
            end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        n_tests++; if (fifo_empty !== 1'b1 || {i_out, q_out} !== 8'h00) begin
            n_fail++; $display("FAIL drain_empty got e=%b data=%h exp 1 00", fifo_empty, {i_out, q_out});
        end
        out_ready = 1'b1; tick();
        n_tests++; if (fill_count !== 4'd0) begin n_fail++; $display("FAIL ready_empty got %0d exp 0", fill_count); end
        write1(4'h3, 4'hC);
        out_ready = 1'b0;
        n_tests++; if (fill_count !== 4'd1 || i_out !== 4'h3 || q_out !== 4'hC) begin
            n_fail++; $display("FAIL wr_rd_empty got cnt=%0d i=%h q=%h exp 1 3 c", fill_count, i_out, q_out);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int bad = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            write1(4'(k), 4'(k + 3));
            if (out_valid !== 1'b1 || i_out !== 4'(k) || q_out !== 4'(k + 3)) begin
                bad++; $display("FAIL wrap_data_%0d got v=%b i=%h q=%h exp 1 %h %h", k, out_valid, i_out, q_out, 4'(k), 4'(k + 3));
            end
            for (int c = 0; c < 5; c++) begin
                if (fill_count > 4'd1) begin bad++; $display("FAIL wrap_count_%0d got %0d exp <=1", k, fill_count); end
                tick();
            end
        end
        n_tests++; if (bad != 0) n_fail++;
        n_tests++; if (overflow !== 1'b0 || fifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL wrap_end got ovf=%b e=%b exp 0 1", overflow, fifo_empty);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) write1(4'(8 + k), 4'(8 + k));
        n_tests++; if (fill_count !== 4'd5) begin n_fail++; $display("FAIL mid_fill got %0d exp 5", fill_count); end
        do_reset();
        n_tests++; if (fifo_empty !== 1'b1 || fill_count !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got e=%b cnt=%0d v=%b exp 1 0 0", fifo_empty, fill_count, out_valid);
        end
        write1(4'hC, 4'h2);
        n_tests++; if (i_out !== 4'hC || q_out !== 4'h2 || fill_count !== 4'd1) begin
            n_fail++; $display("FAIL mid_newdata got i=%h q=%h cnt=%0d exp c 2 1", i_out, q_out, fill_count);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mid_read got e=%b exp 1", fifo_empty); end
    endtask

    initial begin
        tick();
        test_reset();
        test_single_write();
        test_full_threshold();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
